pwm_duty_decoder: RTL and testbench

Receive-side counterpart of the 11-bit PWM generator in the motion subsystem. Samples an asynchronous PWM input, measures its high time and period in clk cycles, and reports an 11-bit duty code on the same scale the generator accepts. A generator driven with duty D on a free-running 2048-cycle frame decodes to duty = D. A timeout reports stuck-low and stuck-high lines. Used for loopback self-test and for decoding externally supplied PWM commands.

---
 rtl/pwm_duty_decoder.sv | 163 ++++++++++++++++
 tb/tb_pwm_duty_decoder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_decoder.sv
// Receive-side PWM decoder: synchronizes pwm_in, measures high time and rise-to-rise
// period in clk cycles, and reports lines held low or high for TIMEOUT cycles.
module pwm_duty_decoder #(
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwm_in,
    output logic [10:0] duty,
    output logic [11:0] period,
    output logic        valid,
    output logic        stuck_lo,
    output logic        stuck_hi
);
    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [11:0]     CNT_MAX = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        HIGH,
        LOW
    } state_t;

    state_t          state, state_nxt;
    logic            s1, s2, s3;
    logic [1:0]      sync_ok;
    logic [11:0]     high_cnt, high_nxt, high_inc;
    logic [11:0]     low_cnt, low_nxt, low_inc;
    logic [TO_W-1:0] to_cnt, to_nxt;
    logic [10:0]     duty_nxt, duty_meas;
    logic [11:0]     period_nxt, period_meas;
    logic [12:0]     period_sum;
    logic            valid_nxt, stuck_lo_nxt, stuck_hi_nxt;
    logic            rise, fall, lvl, primed, timeout;

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;
    assign lvl  = s2;
    // s2 only reflects the pin once two clocks have passed since reset; before that its
    // zero must not arm the FSM or start the timeout, or a line high at release would
    // be measured as a partial period.
    assign primed = (sync_ok == 2'd2);

    assign high_inc = (high_cnt == CNT_MAX) ? high_cnt : high_cnt + 12'd1;
    assign low_inc  = (low_cnt == CNT_MAX) ? low_cnt : low_cnt + 12'd1;

    // The rise cycle itself belongs to the low phase, so the sum uses the incremented low count.
    assign period_sum  = {1'b0, high_cnt} + {1'b0, low_inc};
    assign period_meas = period_sum[12] ? CNT_MAX : period_sum[11:0];
    assign duty_meas   = high_cnt[11] ? 11'h7FF : high_cnt[10:0];

    // Fires only on the single cycle the counter steps onto TIMEOUT; an edge wins.
    assign timeout = primed && !rise && !fall && (to_cnt == TO_LAST);

    // NOTE: every signal written below gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        high_nxt     = high_cnt;
        low_nxt      = low_cnt;
        duty_nxt     = duty;
        period_nxt   = period;
        valid_nxt    = 1'b0;
        stuck_lo_nxt = stuck_lo;
        stuck_hi_nxt = stuck_hi;

        if (rise || fall) begin
            to_nxt = '0;
        end else if (primed && to_cnt != TO_MAX) begin
            to_nxt = to_cnt + 1'b1;
        end else begin
            to_nxt = to_cnt;
        end

        case (state)
            IDLE: begin
                if (primed && !lvl) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (rise) begin
                    high_nxt  = '0;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                high_nxt = high_inc;
                if (fall) begin
                    low_nxt   = '0;
                    state_nxt = LOW;
                end
            end
            LOW: begin
                low_nxt = low_inc;
                if (rise) begin
                    duty_nxt     = duty_meas;
                    period_nxt   = period_meas;
                    stuck_lo_nxt = 1'b0;
                    stuck_hi_nxt = 1'b0;
                    valid_nxt    = 1'b1;
                    high_nxt     = '0;
                    state_nxt    = HIGH;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (timeout) begin
            valid_nxt  = 1'b1;
            period_nxt = '0;
            if (!lvl) begin
                duty_nxt     = '0;
                stuck_lo_nxt = 1'b1;
                stuck_hi_nxt = 1'b0;
                state_nxt    = ARMED;
            end else begin
                duty_nxt     = 11'h7FF;
                stuck_lo_nxt = 1'b0;
                stuck_hi_nxt = 1'b1;
                state_nxt    = IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            sync_ok  <= 2'd0;
            state    <= IDLE;
            high_cnt <= '0;
            low_cnt  <= '0;
            to_cnt   <= '0;
            duty     <= '0;
            period   <= '0;
            valid    <= 1'b0;
            stuck_lo <= 1'b0;
            stuck_hi <= 1'b0;
        end else begin
            s1       <= pwm_in;
            s2       <= s1;
            s3       <= s2;
            if (!primed) begin
                sync_ok <= sync_ok + 2'd1;
            end
            state    <= state_nxt;
            high_cnt <= high_nxt;
            low_cnt  <= low_nxt;
            to_cnt   <= to_nxt;
            duty     <= duty_nxt;
            period   <= period_nxt;
            valid    <= valid_nxt;
            stuck_lo <= stuck_lo_nxt;
            stuck_hi <= stuck_hi_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Self-checking bench for pwm_duty_decoder: drives the line as runs of constant level and
// predicts each valid pulse from the run lengths with a scoreboard queue.
module tb_pwm_duty_decoder;
    localparam int TIMEOUT = 4096;
    localparam int FRAME   = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pwm_in = 1'b0;
    logic [10:0] duty;
    logic [11:0] period;
    logic        valid, stuck_lo, stuck_hi;

    always #5 clk = ~clk;

    pwm_duty_decoder #(.TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pwm_in   (pwm_in),
        .duty     (duty),
        .period   (period),
        .valid    (valid),
        .stuck_lo (stuck_lo),
        .stuck_hi (stuck_hi)
    );

    typedef struct {
        int duty;
        int period;
        bit slo;
        bit shi;
        int gap;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   rel_cyc = 0;
    int   last_valid_cyc = 0;
    int   first_valid_cyc = -1;

    // Line model: current level, its run length so far, and what a decoder should know.
    int m_level, m_run, m_high;
    bit m_armed, m_in_high, m_pend, m_last_meas;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_duty"}, 32'(duty), 0);
        check({tag, "_period"}, 32'(period), 0);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_stuck_lo"}, 32'(stuck_lo), 0);
        check({tag, "_stuck_hi"}, 32'(stuck_hi), 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && valid === 1'b1) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("duty", 32'(duty), mon_e.duty);
                check("period", 32'(period), mon_e.period);
                check("stuck_lo", 32'(stuck_lo), 32'(mon_e.slo));
                check("stuck_hi", 32'(stuck_hi), 32'(mon_e.shi));
                if (mon_e.gap != 0) check("valid_gap", cyc - last_valid_cyc, mon_e.gap);
            end
            last_valid_cyc = cyc;
        end
    end

    task automatic push_meas(input int h, input int l);
        exp_t e;
        e.duty   = (h > 2047) ? 2047 : h;
        e.period = (h + l > 4095) ? 4095 : h + l;
        e.slo    = 1'b0;
        e.shi    = 1'b0;
        e.gap    = m_last_meas ? h + l : 0;
        exp_q.push_back(e);
        m_last_meas = 1'b1;
    endtask

    // Hold the line at 'level' for 'len' sampling clock edges and update the prediction.
    task automatic drive_seg(input int level, input int len);
        exp_t e;
        if (level != m_level) begin
            if (level == 1) begin
                if (m_pend) push_meas(m_high, m_run);
                m_pend    = 1'b0;
                m_in_high = m_armed;
            end else begin
                if (m_in_high) begin
                    m_high = m_run;
                    m_pend = 1'b1;
                end
                m_in_high = 1'b0;
                m_armed   = 1'b1;
            end
            m_level = level;
            m_run   = 0;
        end
        if (m_run < TIMEOUT && m_run + len >= TIMEOUT) begin
            e.duty   = (level == 1) ? 2047 : 0;
            e.period = 0;
            e.slo    = (level == 0);
            e.shi    = (level == 1);
            e.gap    = 0;
            exp_q.push_back(e);
            m_pend      = 1'b0;
            m_in_high   = 1'b0;
            m_armed     = (level == 0);
            m_last_meas = 1'b0;
        end
        m_run += len;
        pwm_in = (level != 0);
        repeat (len) @(posedge clk);
        #1;
    endtask

    // 11-bit generator on a 2048-cycle frame; the requested duty is latched at frame start.
    task automatic run_pwm(input int d_old, input int d_new, input int change_at, input int frames);
        int cur_lvl, run, d_act, d_req, lvl;
        cur_lvl = -1;
        run     = 0;
        d_act   = d_old;
        for (int t = 0; t < frames * FRAME; t++) begin
            d_req = (t < change_at) ? d_old : d_new;
            if (t % FRAME == 0) d_act = d_req;
            lvl = ((t % FRAME) < d_act) ? 1 : 0;
            if (lvl == cur_lvl) begin
                run++;
            end else begin
                if (run > 0) drive_seg(cur_lvl, run);
                cur_lvl = lvl;
                run     = 1;
            end
        end
        drive_seg(cur_lvl, run);
    endtask

    task automatic do_reset(input int level, input string tag);
        rst_n  = 1'b0;
        pwm_in = (level != 0);
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero(tag);
        @(negedge clk);
        rst_n           = 1'b1;
        rel_cyc         = cyc;
        first_valid_cyc = -1;
        m_level         = level;
        m_run           = 0;
        m_armed         = (level == 0);
        m_in_high       = 1'b0;
        m_pend          = 1'b0;
        m_last_meas     = 1'b0;
        m_high          = 0;
    endtask

    task automatic drain(input string tag);
        repeat (5) @(posedge clk);
        #1;
        check({tag, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lvl, len;

        // Line held low from reset, then recovered by a 0x100 PWM.
        do_reset(0, "rst_lo");
        drive_seg(0, TIMEOUT + 50);
        lat = first_valid_cyc - rel_cyc;
        check($sformatf("stuck_lo_latency_%0d", lat),
              32'((lat >= TIMEOUT + 2) && (lat <= TIMEOUT + 4)), 32'd1);
        check("stuck_lo_held", 32'(stuck_lo), 32'd1);
        run_pwm(12'h100, 12'h100, 0, 3);
        drive_seg(1, 5);
        check("stuck_lo_cleared", 32'(stuck_lo), 32'd0);
        drain("stuck_lo");

        // Loopback at duty 0x400.
        do_reset(0, "rst_loop");
        drive_seg(0, 10);
        run_pwm(12'h400, 12'h400, 0, 3);
        drive_seg(1, 5);
        drain("loopback");

        // Duty sweep 1 -> 2047 -> 1024 with mid-frame changes.
        do_reset(0, "rst_sweep");
        drive_seg(0, 10);
        run_pwm(1, 1, 0, 2);
        run_pwm(1, 2047, FRAME + 700, 3);
        run_pwm(2047, 1024, 1000, 3);
        drive_seg(1, 5);
        drain("sweep");

        // Line held high from reset: flagged once, then needs a full period.
        do_reset(1, "rst_hi");
        drive_seg(1, TIMEOUT + 50);
        check("stuck_hi_held", 32'(stuck_hi), 32'd1);
        drive_seg(0, 30);
        drive_seg(1, 500);
        drive_seg(0, 300);
        check("stuck_hi_still", 32'(stuck_hi), 32'd1);
        drive_seg(1, 20);
        check("stuck_hi_cleared", 32'(stuck_hi), 32'd0);
        drain("stuck_hi");

        // Long pulses: duty clamp and period saturation.
        do_reset(0, "rst_long");
        drive_seg(0, 10);
        drive_seg(1, 3000);
        drive_seg(0, 100);
        drive_seg(1, 4000);
        drive_seg(0, 200);
        drive_seg(1, 10);
        drain("long");

        // Reset asserted mid-high; the interrupted period must not be reported.
        do_reset(0, "rst_mid");
        drive_seg(0, 20);
        drive_seg(1, 300);
        drive_seg(0, 200);
        drive_seg(1, 100);
        drain("pre_mid");
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        do_reset(1, "rst_mid2");
        drive_seg(1, 150);
        drive_seg(0, 250);
        drive_seg(1, 400);
        drive_seg(0, 600);
        drive_seg(1, 10);
        drain("post_mid");

        // Random runs, with one forced timeout in the middle.
        do_reset(0, "rst_rand");
        drive_seg(0, 5);
        lvl = 1;
        for (int i = 0; i < 30; i++) begin
            if (i == 15) len = TIMEOUT + 100;
            else if ($urandom_range(7, 0) == 0) len = $urandom_range(3800, 1500);
            else len = $urandom_range(200, 1);
            drive_seg(lvl, len);
            lvl = 1 - lvl;
        end
        if (lvl == 0) drive_seg(0, 5);
        drive_seg(1, 5);
        drain("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
